// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ,
        RESP
    } imem_state_e;

    localparam logic [31:0] IMEM_FAULT_INSN = 32'h0000_0000;

    // Word-index width for a RAM of the given depth in 32-bit words.
    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_load_responder_bank.sv
// Program RAM: synchronous 1W/1R, read-before-write on a same-edge collision.
// The read port can substitute the fault word instead of the stored data.
module imem_bank
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic             clr,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register only changes on a read, so the returned word holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= clr ? IMEM_FAULT_INSN : mem[raddr];
        end
    end

endmodule

// File: rtl/imem_load_responder.sv
// Instruction-memory responder: one load in flight, word returned LATENCY cycles after accept.
// Optional fault detection and err output are enabled with IMEM_ERR_EN.
module imem_load_responder
    import imem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                imem_load_en_i,
    input  logic [DATA_WIDTH-1:0]               imem_load_addr_i,
    output logic [31:0]                         imem_load_insn_o,
    output logic                                imem_load_busy_o,
    output logic                                imem_load_rdy_o,
    input  logic                                abort_i,
    input  logic                                prog_we_i,
    input  logic [idx_width(DEPTH_WORDS)-1:0]   prog_addr_i,
    input  logic [31:0]                         prog_data_i
`ifdef IMEM_ERR_EN
    ,
    output logic                                imem_load_err_o
`endif
);

    localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    // WAIT cycles needed before READ so that RESP lands LATENCY cycles after accept.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 2) ? LATENCY - 2 : 1);

    imem_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             rdy_q;

    logic [IDX_W-1:0] req_idx_c;
    logic             accept_c;
    logic             rd_en_c;
    logic             rd_clr_c;
    logic [IDX_W-1:0] rd_idx_c;

    assign req_idx_c = imem_load_addr_i[IDX_W+1:2];
    assign accept_c  = (state_q == IDLE) && imem_load_en_i && !abort_i;

`ifdef IMEM_ERR_EN
    logic fault_q;
    logic err_q;
    logic req_fault_c;

    assign req_fault_c = (imem_load_addr_i[1:0] != 2'b00) ||
                         (imem_load_addr_i[DATA_WIDTH-1:IDX_W+2] != '0);
`else
    logic unused_addr_c;

    assign unused_addr_c = ^{imem_load_addr_i[DATA_WIDTH-1:IDX_W+2], imem_load_addr_i[1:0]};
`endif

    // RAM read strobe: on the READ edge, or on the accept edge when LATENCY is 1.
    always_comb begin
        rd_en_c  = (state_q == READ) && !abort_i;
        rd_idx_c = idx_q;
        rd_clr_c = 1'b0;
`ifdef IMEM_ERR_EN
        rd_clr_c = fault_q;
`endif
        if (LATENCY == 1) begin
            rd_en_c  = accept_c;
            rd_idx_c = req_idx_c;
`ifdef IMEM_ERR_EN
            rd_clr_c = req_fault_c;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef IMEM_ERR_EN
            fault_q <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            rdy_q <= 1'b0;
`ifdef IMEM_ERR_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        idx_q  <= req_idx_c;
                        busy_q <= 1'b1;
`ifdef IMEM_ERR_EN
                        fault_q <= req_fault_c;
`endif
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            rdy_q   <= 1'b1;
`ifdef IMEM_ERR_EN
                            err_q   <= req_fault_c;
`endif
                        end else if (LATENCY == 2) begin
                            state_q <= READ;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RESP;
                        rdy_q   <= 1'b1;
`ifdef IMEM_ERR_EN
                        err_q   <= fault_q;
`endif
                    end
                end
                RESP: begin
                    // Abort is ignored here: the data pulse is already on the bus.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    imem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (prog_we_i),
        .waddr (prog_addr_i),
        .wdata (prog_data_i),
        .re    (rd_en_c),
        .clr   (rd_clr_c),
        .raddr (rd_idx_c),
        .rdata (imem_load_insn_o)
    );

    assign imem_load_busy_o = busy_q;
    assign imem_load_rdy_o  = rdy_q;
`ifdef IMEM_ERR_EN
    assign imem_load_err_o  = err_q;
`endif

endmodule

// File: tb/tb_imem_load_responder.sv
// Self-checking bench for imem_load_responder: directed vectors plus randomized traffic
// against a cycle-countdown reference model. Build with IMEM_ERR_EN to cover the fault path.
module tb_imem_load_responder;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam int unsigned IW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] addr = '0;
    logic          abort = 1'b0;
    logic          we = 1'b0;
    logic [IW-1:0] paddr = '0;
    logic [31:0]   pdata = '0;
    logic [31:0]   insn;
    logic          busy;
    logic          rdy;
`ifdef IMEM_ERR_EN
    logic          err;
`endif

    imem_load_responder #(
        .DATA_WIDTH  (DW),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_load_en_i   (en),
        .imem_load_addr_i (addr),
        .imem_load_insn_o (insn),
        .imem_load_busy_o (busy),
        .imem_load_rdy_o  (rdy),
        .abort_i          (abort),
        .prog_we_i        (we),
        .prog_addr_i      (paddr),
        .prog_data_i      (pdata)
`ifdef IMEM_ERR_EN
        ,
        .imem_load_err_o  (err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a request is a countdown of edges until its data cycle.
    logic [31:0] mdl_mem [DEPTH];
    int          m_phase = 0;   // 0 idle, 1 pending, 2 data cycle
    int          m_left  = 0;
    int          m_idx   = 0;
    logic        m_fault = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_rdy  = 1'b0;
    logic [31:0] exp_insn = '0;

    function automatic logic [31:0] word(input int i);
        return (32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_phase  = 0;
            exp_insn = '0;
        end else begin
            case (m_phase)
                0: if (en && !abort) begin
                    m_idx = int'((addr >> 2) % 64'(DEPTH));
`ifdef IMEM_ERR_EN
                    m_fault = (addr % 64'd4 != 0) || (addr >= 64'(DEPTH * 4));
`else
                    m_fault = 1'b0;
`endif
                    m_left = int'(LAT) - 1;
                    m_phase = 1;
                    if (m_left == 0) begin
                        m_phase  = 2;
                        exp_insn = m_fault ? 32'h0 : mdl_mem[m_idx];
                    end
                end
                1: if (abort) begin
                    m_phase = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase  = 2;
                        exp_insn = m_fault ? 32'h0 : mdl_mem[m_idx];
                    end
                end
                default: m_phase = 0;
            endcase
        end
        if (we) mdl_mem[paddr] = pdata;
        exp_busy = (m_phase != 0);
        exp_rdy  = (m_phase == 2);
    endtask

    task automatic check_model();
        chk("mdl_busy", 32'(busy), 32'(exp_busy));
        chk("mdl_rdy", 32'(rdy), 32'(exp_rdy));
        chk("mdl_insn", insn, exp_insn);
`ifdef IMEM_ERR_EN
        chk("mdl_err", 32'(err), 32'(exp_rdy && m_fault));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check_model();
    endtask

    // One full request with explicit handshake timing checks.
    task automatic fetch(input string name, input logic [DW-1:0] a, input logic [31:0] w,
                         input logic e);
        en = 1'b1;
        addr = a;
        tick();
        chk({name, "_busy1"}, 32'(busy), 32'd1);
        chk({name, "_rdy1"}, 32'(rdy), 32'd0);
        en = 1'b0;
        tick();
        chk({name, "_rdy2"}, 32'(rdy), 32'd1);
        chk({name, "_busy2"}, 32'(busy), 32'd1);
        chk({name, "_insn"}, insn, w);
`ifdef IMEM_ERR_EN
        chk({name, "_err"}, 32'(err), 32'(e));
`else
        chk({name, "_noerr"}, 32'(e), 32'd0);
`endif
        tick();
        chk({name, "_busy3"}, 32'(busy), 32'd0);
        chk({name, "_rdy3"}, 32'(rdy), 32'd0);
    endtask

    typedef struct {
        logic [DW-1:0] a;
        logic [31:0]   w;
        logic          e;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [DW-1:0] rand_addr();
        logic [DW-1:0] a;
        a = 64'($urandom_range(0, 15)) * 64'd4;
        if ($urandom_range(0, 3) == 0) a = a | 64'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) a = a + (64'($urandom_range(1, 255)) << 12);
        return a;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int last;

        vecs[0] = '{64'h0, word(0), 1'b0};
        vecs[1] = '{64'h4, word(1), 1'b0};
        vecs[2] = '{64'h1C, word(7), 1'b0};
`ifdef IMEM_ERR_EN
        vecs[3] = '{64'h1008, 32'h0, 1'b1};
        vecs[4] = '{64'hFFFF_0000_0000_003C, 32'h0, 1'b1};
`else
        vecs[3] = '{64'h1008, word(2), 1'b0};
        vecs[4] = '{64'hFFFF_0000_0000_003C, word(15), 1'b0};
`endif

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_insn", insn, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            we = 1'b1;
            paddr = IW'(i);
            pdata = word(i);
            tick();
        end
        we = 1'b0;
        tick();

        fetch("t1", 64'h0, 32'h0010_0093, 1'b0);
        fetch("t1b", 64'h4, 32'h0020_0113, 1'b0);

        for (int i = 0; i < 5; i++) fetch($sformatf("vec%0d", i), vecs[i].a, vecs[i].w, vecs[i].e);

        // Back-to-back requests with en held high
        en = 1'b1;
        addr = '0;
        k = 0;
        last = -1;
        for (int c = 0; c < 16 && k < 4; c++) begin
            tick();
            if (rdy) begin
                chk("t2_insn", insn, word(k));
                if (last >= 0) chk("t2_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                k++;
                addr = 64'(k) * 64'd4;
            end
        end
        chk("t2_count", 32'(k), 32'd4);
        en = 1'b0;
        repeat (2) tick();

        // Abort in the cycle after accept
        en = 1'b1;
        addr = 64'h4;
        tick();
        en = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_rdy", 32'(rdy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_norsp", 32'(rdy), 32'd0);
        end
        fetch("t3_refetch", 64'h4, word(1), 1'b0);

        // Loader write on the same edge as the RAM read
        en = 1'b1;
        addr = 64'd20;
        tick();
        en = 1'b0;
        we = 1'b1;
        paddr = IW'(5);
        pdata = 32'hDEAD_BEEF;
        tick();
        we = 1'b0;
        chk("t4_rdy", 32'(rdy), 32'd1);
        chk("t4_old", insn, word(5));
        tick();
        fetch("t4_new", 64'd20, 32'hDEAD_BEEF, 1'b0);

        // Reset while a request is in flight
        en = 1'b1;
        addr = 64'h8;
        tick();
        en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rdy", 32'(rdy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_norsp", 32'(rdy), 32'd0);
        end

`ifdef IMEM_ERR_EN
        fetch("t6_mis", 64'h2, 32'h0, 1'b1);
        fetch("t6_high", 64'h1 << 20, 32'h0, 1'b1);
`else
        fetch("t6_mis", 64'h2, word(0), 1'b0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            en    = $urandom_range(0, 1) == 1;
            abort = ($urandom_range(0, 9) == 0);
            we    = !rst && ($urandom_range(0, 2) == 0);
            paddr = IW'($urandom_range(0, 15));
            pdata = $urandom;
            addr  = rand_addr();
            tick();
        end
        rst = 1'b0;
        en = 1'b0;
        abort = 1'b0;
        we = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
